spi_ram_arbiter: RTL

Owns the single-port RAM and shares it between two requesters: the SPI slave's decoded 10-bit frame stream and a local host port. SPI frames are decoded into address-latch, write and read operations. Read data returns to the slave on tx_data/tx_valid. The host gets a request/grant port with single-cycle read-return pulses.

---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/spi_frame_capture.sv | 92 +++++++++
 rtl/spi_ram_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI/host RAM arbiter: frame command codes and arbiter states.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPI_ISSUE  = 3'd1,
    SPI_RDATA  = 3'd2,
    HOST_ISSUE = 3'd3,
    HOST_RDATA = 3'd4
  } arb_state_e;

  function automatic logic is_data_cmd(input logic [1:0] cmd);
    return (cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA);
  endfunction

endpackage

// File: rtl/spi_frame_capture.sv
// Turns the SPI slave's 10-bit frame stream into address latches and a single
// pending RAM operation slot, flagging frames that arrive while the slot is full.
module spi_frame_capture
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_pend_clr,
  output logic                  o_pend,
  output logic                  o_pend_we,
  output logic [ADDR_WIDTH-1:0] o_pend_addr,
  output logic [DATA_WIDTH-1:0] o_pend_wdata,
  output logic                  o_overrun
);

  logic                  r_rx_valid_q;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_pend;
  logic                  r_pend_we;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic [DATA_WIDTH-1:0] r_pend_wdata;
  logic                  r_overrun;

  logic                  w_edge;
  logic [1:0]            w_cmd;
  logic                  w_accept;

  assign w_cmd    = i_rx_data[9:8];
  assign w_edge   = i_rx_valid & ~r_rx_valid_q;
  assign w_accept = w_edge & is_data_cmd(w_cmd) & ~r_pend;

  // Edge detector and address latches; address frames apply even during overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid_q <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
    end else begin
      r_rx_valid_q <= i_rx_valid;
      if (w_edge && (w_cmd == CMD_WR_ADDR)) begin
        r_wr_addr <= i_rx_data[ADDR_WIDTH-1:0];
      end
      if (w_edge && (w_cmd == CMD_RD_ADDR)) begin
        r_rd_addr <= i_rx_data[ADDR_WIDTH-1:0];
      end
    end
  end

  // Pending slot: filled by a data frame, emptied when the arbiter issues it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
    end else if (w_accept) begin
      r_pend    <= 1'b1;
      r_pend_we <= (w_cmd == CMD_WR_DATA);
      if (w_cmd == CMD_WR_DATA) begin
        r_pend_addr  <= r_wr_addr;
        r_pend_wdata <= i_rx_data[DATA_WIDTH-1:0];
      end else begin
        r_pend_addr  <= r_rd_addr;
        r_pend_wdata <= '0;
      end
    end else if (i_pend_clr) begin
      r_pend <= 1'b0;
    end
  end

  // Sticky overrun: any new frame while the slot is still occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_edge && r_pend) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_pend       = r_pend;
  assign o_pend_we    = r_pend_we;
  assign o_pend_addr  = r_pend_addr;
  assign o_pend_wdata = r_pend_wdata;
  assign o_overrun    = r_overrun;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Single-port RAM owner arbitrating between decoded SPI frames (fixed priority)
// and a local host request/grant port.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  spi_overrun
);

  arb_state_e            r_state;
  arb_state_e            w_next;

  logic                  w_pend;
  logic                  w_pend_we;
  logic [ADDR_WIDTH-1:0] w_pend_addr;
  logic [DATA_WIDTH-1:0] w_pend_wdata;
  logic                  w_overrun;

  logic                  w_pend_clr;
  logic                  w_spi_cap;
  logic                  w_host_cap;
  logic                  w_ram_en_d;
  logic                  w_ram_we_d;
  logic [ADDR_WIDTH-1:0] w_ram_addr_d;
  logic [DATA_WIDTH-1:0] w_ram_wdata_d;
  logic                  w_host_gnt_d;

  logic                  r_ram_en;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic                  r_host_gnt;
  logic                  r_host_we;
  logic [DATA_WIDTH-1:0] r_host_rdata;
  logic                  r_host_rvalid;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid;

  spi_frame_capture #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_pend_clr   (w_pend_clr),
    .o_pend       (w_pend),
    .o_pend_we    (w_pend_we),
    .o_pend_addr  (w_pend_addr),
    .o_pend_wdata (w_pend_wdata),
    .o_overrun    (w_overrun)
  );

  // Arbiter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; SPI wins ties, and the host op type was latched on issue
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_pend) begin
          w_next = SPI_ISSUE;
        end else if (host_req) begin
          w_next = HOST_ISSUE;
        end else begin
          w_next = IDLE;
        end
      end
      SPI_ISSUE: begin
        if (w_pend_we) begin
          w_next = IDLE;
        end else begin
          w_next = SPI_RDATA;
        end
      end
      HOST_ISSUE: begin
        if (r_host_we) begin
          w_next = IDLE;
        end else begin
          w_next = HOST_RDATA;
        end
      end
      SPI_RDATA:  w_next = IDLE;
      HOST_RDATA: w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Output decode: RAM strobes are staged from the next state so they land in ISSUE
  always_comb begin
    w_pend_clr    = (r_state == SPI_ISSUE);
    w_spi_cap     = (r_state == SPI_RDATA);
    w_host_cap    = (r_state == HOST_RDATA);
    w_ram_en_d    = 1'b0;
    w_ram_we_d    = 1'b0;
    w_ram_addr_d  = '0;
    w_ram_wdata_d = '0;
    w_host_gnt_d  = 1'b0;
    case (w_next)
      SPI_ISSUE: begin
        w_ram_en_d    = 1'b1;
        w_ram_we_d    = w_pend_we;
        w_ram_addr_d  = w_pend_addr;
        w_ram_wdata_d = w_pend_wdata;
      end
      HOST_ISSUE: begin
        w_ram_en_d    = 1'b1;
        w_ram_we_d    = host_we;
        w_ram_addr_d  = host_addr;
        w_ram_wdata_d = host_wdata;
        w_host_gnt_d  = 1'b1;
      end
      default: begin
        w_ram_en_d = 1'b0;
      end
    endcase
  end

  // RAM port and host grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_host_gnt  <= 1'b0;
      r_host_we   <= 1'b0;
    end else begin
      r_ram_en    <= w_ram_en_d;
      r_ram_we    <= w_ram_we_d;
      r_ram_addr  <= w_ram_addr_d;
      r_ram_wdata <= w_ram_wdata_d;
      r_host_gnt  <= w_host_gnt_d;
      if (w_host_gnt_d) begin
        r_host_we <= host_we;
      end
    end
  end

  // Host read return: one-cycle valid, data held until the next host read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_host_rvalid <= w_host_cap;
      if (w_host_cap) begin
        r_host_rdata <= ram_rdata;
      end
    end
  end

  // SPI read return: held while the frame is selected, dropped once rx_valid falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (w_spi_cap) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= ram_rdata;
    end else if (!rx_valid) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign ram_en      = r_ram_en;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign host_gnt    = r_host_gnt;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign spi_overrun = w_overrun;

endmodule
